calc_request_responder: RTL and testbench
=========================================

// Module: calc_request_responder
// PURPOSE
//  Sequential, handshaked responder for the 4-bit-opcode calculator operation set.
//  - Accepts one request (op, two operands) on a valid/ready channel.
//  - Executes it: single-cycle for add/sub/logic/shift; Nbits-cycle iterative for mul/div/mod.
//  - Returns the result on a valid/ready response channel.
//  - Sits between a request initiator (bench sequencer, UI controller) and downstream result consumers.
// PARAMETERS
//  Nbits  4  operand width; result width is 2*Nbits; legal range >= 2
// PORTS
//  clock      in   1          single clock, rising edge
//  reset      in   1          asynchronous, active-high
//  req_valid  in   1          request present
//  req_ready  out  1          responder can accept; high only in IDLE
//  op_select  in   4          opcode, sampled at accept
//  operand1   in   Nbits      first operand (unsigned), sampled at accept
//  operand2   in   Nbits      second operand (unsigned), sampled at accept
//  resp_valid out  1          result available
//  resp_ready in   1          consumer takes result
//  resultado  out  2*Nbits    result, held stable while resp_valid
//  err        out  1          divide/mod by zero or illegal opcode; qualified by resp_valid
// BEHAVIOUR
//  Reset values:
//  - state = IDLE; req_ready = 1; resp_valid = 0; resultado = 0; err = 0.
//  - Internal operand, accumulator and counter registers are cleared.
//  Accept and response handshakes:
//  - Accept = req_valid && req_ready at a rising edge.
//  - Operands and opcode are latched at accept; later input changes are ignored.
//  - A response transfers when resp_valid && resp_ready at a rising edge.
//  State machine (IDLE, EXEC, RESP):
//  - IDLE -> RESP on accept of a single-cycle op. resp_valid is high in the 1st cycle after accept.
//  - IDLE -> EXEC on accept of mul, div or mod with a nonzero divisor. The counter loads Nbits.
//  - EXEC: one shift-add (mul) or restoring-division step (div/mod) per cycle.
//  - EXEC -> RESP when the counter reaches 0. resp_valid is high Nbits+1 cycles after accept.
//  - RESP -> IDLE on resp_valid && resp_ready.
//  - In RESP, resultado and err hold while resp_ready = 0; req_ready stays 0.
//  - No accept occurs in the same cycle as a response transfer. The next accept is possible from the following cycle.
//  Opcodes (a = operand1, b = operand2, both zero-extended to 2*Nbits; result is modulo 2^(2*Nbits)):
//  - 0000 add = a+b
//  - 0001 sub = a-b, two's complement
//  - 0010 mul = a*b
//  - 0011 div = a/b, quotient
//  - 0100 mod = a%b
//  - 0101 and = a&b
//  - 0110 or  = a|b
//  - 0111 xor = a^b
//  - 1000 shl = a<<b
//  - 1001 shr = a>>b (logical)
//  - Shift amounts >= 2*Nbits give 0.
//  Error cases:
//  - div with b=0: resultado = all ones, err = 1. Skips EXEC; resp_valid is high the 1st cycle after accept.
//  - mod with b=0: resultado = a, err = 1. Same single-cycle latency.
//  - Opcodes 1010-1111: resultado = 0, err = 1, single-cycle latency.
//  - err = 0 for all other results.
//  Reset mid-operation:
//  - Asserting reset in any state aborts the operation immediately (asynchronously).
//  - All outputs return to their reset values; the partial result is discarded; no response is produced.
// TESTING
//  1. Latency: add 0101+0011, resp_ready=1 -> resultado=8'h08, err=0, resp_valid exactly 1 cycle after accept.
//     Sub 0011-0101 -> 8'hFE.
//  2. Iterative mul: mul 1111*0011 -> resultado=8'h2D, resp_valid exactly 5 cycles after accept.
//     req_ready=0 throughout.
//  3. Division: div 1110/0010 -> 8'h07 after 5 cycles; mod 1111%0010 -> 8'h01.
//     div 0011/0000 -> 8'hFF, err=1, 1-cycle latency.
//  4. Backpressure: mul 0011*0011 with resp_ready=0 for 3 cycles after resp_valid.
//     resultado=8'h09 stable; req_ready=0; operand changes are ignored; transfer on resp_ready=1, then req_ready=1.
//  5. Reset mid-EXEC: assert reset during the 2nd EXEC cycle of div 1110/0010.
//     Outputs are 0 and req_ready=1 immediately; no stale resp_valid; next add 0001+0001 -> 8'h02.
//  6. Shift and illegal opcode: shl 1110<<0010 -> 8'h38; shr 0011>>0011 -> 8'h00.
//     op 1010 -> resultado=8'h00, err=1.

Source files
------------

// File: rtl/calc_request_responder_if.sv
// Request/response channel between a calculator initiator and the responder.
// The initiator drives the request fields and resp_ready; the responder drives the rest.
interface calc_request_responder_if #(
  parameter int Nbits = 4
);
  logic               req_valid;
  logic               req_ready;
  logic [3:0]         op_select;
  logic [Nbits-1:0]   operand1;
  logic [Nbits-1:0]   operand2;
  logic               resp_valid;
  logic               resp_ready;
  logic [2*Nbits-1:0] resultado;
  logic               err;

  modport master (
    output req_valid, op_select, operand1, operand2, resp_ready,
    input  req_ready, resp_valid, resultado, err
  );

  modport slave (
    input  req_valid, op_select, operand1, operand2, resp_ready,
    output req_ready, resp_valid, resultado, err
  );
endinterface

// File: rtl/calc_request_responder.sv
// Handshaked calculator: single-cycle arithmetic/logic/shift ops, Nbits-step
// iterative shift-add multiply and restoring divide/modulo.
module calc_request_responder #(
  parameter int Nbits = 4
) (
  input logic                    clock,
  input logic                    reset,
  calc_request_responder_if.slave bus
);
  localparam int W  = 2*Nbits;
  localparam int CW = $clog2(Nbits+1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;

  logic [3:0]    op_q;
  logic [W-1:0]  a_q, b_q, acc_q, res_q;
  logic [CW-1:0] cnt_q;
  logic          err_q;

  logic          accept, req_ready, resp_valid;
  logic [W-1:0]  a_w, b_w, res_1c;
  logic          err_1c, iter;
  logic [W-1:0]  mul_acc, rem_sh, rem_nx, quo_nx, fin;
  logic          rem_ge;

  assign a_w    = {{Nbits{1'b0}}, bus.operand1};
  assign b_w    = {{Nbits{1'b0}}, bus.operand2};
  assign accept = bus.req_valid && req_ready;

  // Result of the ops that finish at accept; iter flags the multi-cycle ones.
  always_comb begin
    res_1c = '0;
    err_1c = 1'b0;
    iter   = 1'b0;
    case (bus.op_select)
      4'h0: res_1c = a_w + b_w;
      4'h1: res_1c = a_w - b_w;
      4'h2: iter = 1'b1;
      4'h3: if (b_w == '0) begin res_1c = '1;  err_1c = 1'b1; end else iter = 1'b1;
      4'h4: if (b_w == '0) begin res_1c = a_w; err_1c = 1'b1; end else iter = 1'b1;
      4'h5: res_1c = a_w & b_w;
      4'h6: res_1c = a_w | b_w;
      4'h7: res_1c = a_w ^ b_w;
      4'h8: res_1c = (b_w >= W'(W)) ? '0 : a_w << b_w;
      4'h9: res_1c = (b_w >= W'(W)) ? '0 : a_w >> b_w;
      default: err_1c = 1'b1;
    endcase
  end

  // One iteration step: a_q is multiplicand (mul) or dividend/quotient shifter (div/mod).
  always_comb begin
    mul_acc = b_q[0] ? acc_q + a_q : acc_q;
    rem_sh  = {acc_q[W-2:0], a_q[Nbits-1]};
    rem_ge  = rem_sh >= b_q;
    rem_nx  = rem_ge ? rem_sh - b_q : rem_sh;
    quo_nx  = {a_q[W-2:0], rem_ge};
    case (op_q)
      4'h2:    fin = mul_acc;
      4'h3:    fin = {{Nbits{1'b0}}, quo_nx[Nbits-1:0]};
      default: fin = rem_nx;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) state_nx = iter ? EXEC : RESP;
      end
      EXEC: if (cnt_q == CW'(1)) state_nx = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (bus.resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q  <= bus.op_select;
          a_q   <= a_w;
          b_q   <= b_w;
          acc_q <= '0;
          cnt_q <= CW'(Nbits);
          res_q <= res_1c;
          err_q <= err_1c;
        end
        EXEC: begin
          cnt_q <= cnt_q - CW'(1);
          if (op_q == 4'h2) begin
            acc_q <= mul_acc;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
          end else begin
            acc_q <= rem_nx;
            a_q   <= quo_nx;
          end
          // Last step writes straight into the result so RESP starts with it.
          if (cnt_q == CW'(1)) res_q <= fin;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid;
  assign bus.resultado  = res_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_calc_request_responder.sv
// Directed vector table plus randomized transactions against an arithmetic model.
module tb_calc_request_responder;
  localparam int N    = 4;
  localparam int W    = 2*N;
  localparam int MASK = (1 << W) - 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  calc_request_responder_if #(.Nbits(N)) bus();
  calc_request_responder #(.Nbits(N)) dut (.clock(clock), .reset(reset), .bus(bus));

  typedef struct {
    logic [3:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    int           dly;
    logic [W-1:0] res;
    logic         err;
    int           lat;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // {err, result} straight from the opcode definitions, using integer arithmetic.
  function automatic logic [W:0] model(input int op, input int a, input int b);
    int   r = 0;
    logic e = 1'b0;
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = a * b;
      3: if (b == 0) begin r = MASK; e = 1'b1; end else r = a / b;
      4: if (b == 0) begin r = a;    e = 1'b1; end else r = a % b;
      5: r = a & b;
      6: r = a | b;
      7: r = a ^ b;
      8: r = (b >= W) ? 0 : (a << b);
      9: r = (b >= W) ? 0 : (a >> b);
      default: e = 1'b1;
    endcase
    return {e, W'(r & MASK)};
  endfunction

  function automatic int model_lat(input int op, input int b);
    return (op == 2 || ((op == 3 || op == 4) && b != 0)) ? N + 1 : 1;
  endfunction

  // Issue one request, hold off resp_ready for dly cycles, then complete the transfer.
  task automatic run_txn(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                         input int dly, input string nm,
                         output logic [W-1:0] res, output logic e, output int lat);
    logic busy_ok = 1'b1;
    logic hold_ok = 1'b1;
    res = '0; e = 1'b0; lat = 0;
    @(negedge clock);
    chk($sformatf("%s req_ready idle", nm), 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.op_select  = op;
    bus.operand1   = a;
    bus.operand2   = b;
    bus.resp_ready = (dly == 0);
    @(posedge clock);
    #1;
    bus.req_valid = 1'b0;
    bus.op_select = 4'($urandom);
    bus.operand1  = N'($urandom);
    bus.operand2  = N'($urandom);
    while (lat < 20) begin
      @(negedge clock);
      lat++;
      if (bus.req_ready) busy_ok = 1'b0;
      if (bus.resp_valid) break;
    end
    if (!bus.resp_valid) begin
      chk($sformatf("%s timeout", nm), 32'(bus.resp_valid), 32'd1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      bus.resp_ready = 1'b0;
      return;
    end
    res = bus.resultado;
    e   = bus.err;
    chk($sformatf("%s req_ready busy", nm), 32'(busy_ok), 32'd1);
    for (int d = 0; d < dly; d++) begin
      @(negedge clock);
      if (bus.resultado !== res || bus.err !== e || !bus.resp_valid || bus.req_ready)
        hold_ok = 1'b0;
    end
    if (dly > 0) chk($sformatf("%s held", nm), 32'(hold_ok), 32'd1);
    bus.resp_ready = 1'b1;
    @(negedge clock);
    chk($sformatf("%s released", nm), 32'({bus.resp_valid, bus.req_ready}), 32'b01);
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] r;
    logic         e;
    logic [W:0]   m;
    int           lat;
    logic         stale;
    logic [3:0]   op;
    logic [N-1:0] a, b;

    bus.req_valid = 1'b0; bus.op_select = '0; bus.operand1 = '0;
    bus.operand2  = '0;   bus.resp_ready = 1'b0;

    vt[0]  = '{4'h0, 4'h5, 4'h3, 0, 8'h08, 1'b0, 1};
    vt[1]  = '{4'h1, 4'h3, 4'h5, 0, 8'hFE, 1'b0, 1};
    vt[2]  = '{4'h2, 4'hF, 4'h3, 0, 8'h2D, 1'b0, 5};
    vt[3]  = '{4'h3, 4'hE, 4'h2, 0, 8'h07, 1'b0, 5};
    vt[4]  = '{4'h4, 4'hF, 4'h2, 0, 8'h01, 1'b0, 5};
    vt[5]  = '{4'h3, 4'h3, 4'h0, 0, 8'hFF, 1'b1, 1};
    vt[6]  = '{4'h4, 4'h7, 4'h0, 1, 8'h07, 1'b1, 1};
    vt[7]  = '{4'h2, 4'h3, 4'h3, 3, 8'h09, 1'b0, 5};
    vt[8]  = '{4'h8, 4'hE, 4'h2, 0, 8'h38, 1'b0, 1};
    vt[9]  = '{4'h9, 4'h3, 4'h3, 0, 8'h00, 1'b0, 1};
    vt[10] = '{4'hA, 4'h5, 4'h5, 0, 8'h00, 1'b1, 1};
    vt[11] = '{4'h8, 4'h1, 4'h7, 0, 8'h80, 1'b0, 1};
    vt[12] = '{4'h8, 4'h1, 4'h8, 0, 8'h00, 1'b0, 1};
    vt[13] = '{4'h2, 4'hF, 4'hF, 2, 8'hE1, 1'b0, 5};
    vt[14] = '{4'h7, 4'hC, 4'hA, 0, 8'h06, 1'b0, 1};
    vt[15] = '{4'hF, 4'h0, 4'h0, 0, 8'h00, 1'b1, 1};

    #3;
    chk("reset outputs", 32'({bus.req_ready, bus.resp_valid, bus.err, bus.resultado}),
        32'({1'b1, 1'b0, 1'b0, 8'h00}));
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      run_txn(vt[i].op, vt[i].a, vt[i].b, vt[i].dly, $sformatf("vec%0d", i), r, e, lat);
      chk($sformatf("vec%0d result", i),  32'(r),   32'(vt[i].res));
      chk($sformatf("vec%0d err", i),     32'(e),   32'(vt[i].err));
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vt[i].lat));
    end

    // Abort a division during its second iteration cycle.
    @(negedge clock);
    bus.req_valid = 1'b1; bus.op_select = 4'h3; bus.operand1 = 4'hE; bus.operand2 = 4'h2;
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("midexec reset outputs", 32'({bus.req_ready, bus.resp_valid, bus.err, bus.resultado}),
        32'({1'b1, 1'b0, 1'b0, 8'h00}));
    @(negedge clock);
    reset = 1'b0;
    stale = 1'b0;
    repeat (8) begin
      @(negedge clock);
      if (bus.resp_valid) stale = 1'b1;
    end
    chk("midexec no stale resp", 32'(stale), 32'd0);
    run_txn(4'h0, 4'h1, 4'h1, 0, "after reset", r, e, lat);
    chk("after reset result", 32'(r), 32'h02);
    chk("after reset err",    32'(e), 32'd0);

    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = N'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      run_txn(op, a, b, $urandom_range(0, 2), $sformatf("rnd%0d", i), r, e, lat);
      m = model(int'(op), int'(a), int'(b));
      chk($sformatf("rnd%0d op%0h %0h,%0h result", i, op, a, b), 32'(r), 32'(m[W-1:0]));
      chk($sformatf("rnd%0d err", i),     32'(e),   32'(m[W]));
      chk($sformatf("rnd%0d latency", i), 32'(lat), 32'(model_lat(int'(op), int'(b))));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
